fan_adc_filter: RTL and testbench

Input conditioning stage that sits directly upstream of the fan controller's ADC input. It synchronises the raw 4-bit temperature ADC code and decimates it with a prescaled sample tick. It then produces a rounded moving average over 2^AVG_LOG2 samples as the controller's ADC value, which suppresses LSB flicker that would otherwise drive PWM jitter.

---
 rtl/fan_adc_filter.sv | 190 +++++++++++++++++++
 tb/tb_fan_adc_filter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fan_adc_filter.sv
// fan_adc_filter
//
// Conditions the raw temperature ADC code before it reaches the fan
// controller. The asynchronous code is brought into the clock domain through a
// two-flop synchroniser, decimated by a prescaled sample tick, and averaged
// over a window of 2^AVG_LOG2 samples with round-half-up rounding. The
// averaging removes LSB flicker that would otherwise show up as PWM jitter.
//
// Parameters:
//   ADC_BITWIDTH  width of the raw and filtered ADC code
//   AVG_LOG2      log2 of the averaging window length (1..4)
//   PRESCALE      enabled clock cycles per sample tick (>= 1)
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   clk_en_i     clock enable; the prescaler only advances while high
//   ADC_value_i  raw ADC code, asynchronous to clk_i
//   ADC_value_o  filtered ADC code, registered
//   valid_o      one-cycle pulse each time ADC_value_o is re-evaluated
//   ready_o      set with the first valid_o once the window is full
//
// Optional feature:
//   ADC_FILTER_HYST_EN  when defined, after the first output ADC_value_o only
//                       follows the average when it differs by 2 or more.

module fan_adc_filter #(
  parameter int ADC_BITWIDTH = 4,
  parameter int AVG_LOG2     = 2,
  parameter int PRESCALE     = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic [ADC_BITWIDTH-1:0] ADC_value_i,
  output logic [ADC_BITWIDTH-1:0] ADC_value_o,
  output logic                    valid_o,
  output logic                    ready_o
);

  localparam int WIN     = 1 << AVG_LOG2;
  localparam int SUM_W   = ADC_BITWIDTH + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  // A one-entry prescaler still needs a one-bit counter to exist.
  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
  localparam logic [SUM_W-1:0]   ROUND     = SUM_W'(WIN / 2);
  localparam logic [CNT_W-1:0]   FILL_LAST = CNT_W'(WIN - 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [ADC_BITWIDTH-1:0] adc_meta;
  logic [ADC_BITWIDTH-1:0] adc_s;
  logic [PRESC_W-1:0]      presc;
  logic                    tick;
  logic [ADC_BITWIDTH-1:0] win_buf [WIN];
  logic [AVG_LOG2-1:0]     wp;
  logic [SUM_W-1:0]        sum;
  logic [CNT_W-1:0]        fill_cnt;
  logic                    eval;
  logic                    eval_q;
  logic [SUM_W-1:0]        rounded;
  logic [ADC_BITWIDTH-1:0] avg;
  logic                    load_avg;
  logic                    unused_round_bits;

  // Two-flop synchroniser, free running so the sample is always fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adc_meta <= '0;
      adc_s    <= '0;
    end else begin
      adc_meta <= ADC_value_i;
      adc_s    <= adc_meta;
    end
  end

  assign tick = clk_en_i && (presc == PRESC_MAX);

  // Prescaler: freezes while the enable is low so a stall never loses phase.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc <= '0;
    end else if (clk_en_i) begin
      presc <= tick ? '0 : presc + PRESC_W'(1);
    end
  end

  // Circular window with running sum. The sum is kept exact by adding the
  // new sample and removing the one it overwrites; intermediate wrap-around
  // cancels because the final value always fits in SUM_W bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < WIN; i++) begin
        win_buf[i] <= '0;
      end
      wp  <= '0;
      sum <= '0;
    end else if (tick) begin
      win_buf[wp] <= adc_s;
      sum         <= sum + SUM_W'(adc_s) - SUM_W'(win_buf[wp]);
      wp          <= wp + AVG_LOG2'(1);
    end
  end

  // Fill counter only matters until the window has been filled once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_cnt <= '0;
    end else if (tick && (state == FILL)) begin
      fill_cnt <= fill_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // The tick that writes the last fill entry already produces an output.
  always_comb begin
    state_nxt = state;
    eval      = 1'b0;
    case (state)
      FILL: begin
        if (tick && (fill_cnt == FILL_LAST)) begin
          state_nxt = RUN;
          eval      = 1'b1;
        end
      end
      RUN: begin
        eval = tick;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // The average is taken from the sum one cycle after the tick updated it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eval_q <= 1'b0;
    end else begin
      eval_q <= eval;
    end
  end

  assign rounded           = sum + ROUND;
  assign avg               = rounded[SUM_W-1:AVG_LOG2];
  assign unused_round_bits = ^rounded[AVG_LOG2-1:0];

`ifdef ADC_FILTER_HYST_EN
  logic [ADC_BITWIDTH-1:0] avg_diff;

  // ready_o is still low on the first output, so that one always loads.
  always_comb begin
    avg_diff = (avg >= ADC_value_o) ? (avg - ADC_value_o) : (ADC_value_o - avg);
    load_avg = !ready_o || (avg_diff >= ADC_BITWIDTH'(2));
  end
`else
  assign load_avg = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ADC_value_o <= '0;
      valid_o     <= 1'b0;
      ready_o     <= 1'b0;
    end else begin
      valid_o <= eval_q;
      if (eval_q) begin
        ready_o <= 1'b1;
        if (load_avg) begin
          ADC_value_o <= avg;
        end
      end
    end
  end

endmodule

// File: tb/tb_fan_adc_filter.sv
// tb_fan_adc_filter
//
// Directed self-checking bench for fan_adc_filter with ADC_BITWIDTH=4,
// AVG_LOG2=2, PRESCALE=4. Expected values are hand computed from the
// averaging rule (sum + 2) >> 2. Define ADC_FILTER_HYST_EN for both the bench
// and the design to exercise the hysteresis variant.

`timescale 1ns/1ps

module tb_fan_adc_filter;

  localparam int ADC_BITWIDTH = 4;
  localparam int AVG_LOG2     = 2;
  localparam int PRESCALE     = 4;

`ifdef ADC_FILTER_HYST_EN
  localparam int HYST = 1;
`else
  localparam int HYST = 0;
`endif

  logic                    clk_i;
  logic                    rst_i;
  logic                    clk_en_i;
  logic [ADC_BITWIDTH-1:0] ADC_value_i;
  logic [ADC_BITWIDTH-1:0] ADC_value_o;
  logic                    valid_o;
  logic                    ready_o;

  int total;
  int bad;

  fan_adc_filter #(
    .ADC_BITWIDTH(ADC_BITWIDTH),
    .AVG_LOG2    (AVG_LOG2),
    .PRESCALE    (PRESCALE)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clk_en_i   (clk_en_i),
    .ADC_value_i(ADC_value_i),
    .ADC_value_o(ADC_value_o),
    .valid_o    (valid_o),
    .ready_o    (ready_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are driven and outputs
  // sampled there.
  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    #1;
    stepCycle();
    rst_i = 1'b0;
  endtask

  // Produces exactly one sample tick on value v: the input settles through
  // the synchroniser with the enable low, then four enabled cycles bring the
  // prescaler from 0 to its tick. Leaves the bench just after the tick edge.
  task automatic applyStimulus(input int v);
    ADC_value_i = ADC_BITWIDTH'(v);
    clk_en_i    = 1'b0;
    repeat (3) stepCycle();
    clk_en_i = 1'b1;
    repeat (4) stepCycle();
    clk_en_i = 1'b0;
  endtask

  // One tick followed by a check of the cycle where its result must appear.
  task automatic tickAndCheck(input string tag, input int v, input int exp_valid,
                              input int exp_value, input int exp_ready);
    applyStimulus(v);
    checkOutput({tag, "_valid_early"}, int'(valid_o), 0);
    stepCycle();
    checkOutput({tag, "_valid"}, int'(valid_o), exp_valid);
    checkOutput({tag, "_value"}, int'(ADC_value_o), exp_value);
    checkOutput({tag, "_ready"}, int'(ready_o), exp_ready);
    stepCycle();
    checkOutput({tag, "_valid_late"}, int'(valid_o), 0);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_i       = 1'b0;
    clk_en_i    = 1'b0;
    ADC_value_i = '0;

    // Asynchronous reset asserted between clock edges.
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("rst_async_value", int'(ADC_value_o), 0);
    checkOutput("rst_async_valid", int'(valid_o), 0);
    checkOutput("rst_async_ready", int'(ready_o), 0);
    ADC_value_i = 4'd9;
    clk_en_i    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("rst_hold_value", int'(ADC_value_o), 0);
      checkOutput("rst_hold_valid", int'(valid_o), 0);
      checkOutput("rst_hold_ready", int'(ready_o), 0);
    end
    rst_i = 1'b0;

    // Constant 9 with the enable held high: ticks end at edges 4,8,12,16,20,
    // 24; the fourth tick gives the first output after edge 17.
    for (int k = 1; k <= 24; k++) begin
      stepCycle();
      checkOutput($sformatf("fill9_valid_c%0d", k), int'(valid_o),
                  (k == 17 || k == 21) ? 1 : 0);
      checkOutput($sformatf("fill9_ready_c%0d", k), int'(ready_o), (k >= 17) ? 1 : 0);
      checkOutput($sformatf("fill9_value_c%0d", k), int'(ADC_value_o), (k >= 17) ? 9 : 0);
    end
    clk_en_i = 1'b0;
    repeat (3) stepCycle();

    // Step response from a window of zeros.
    doReset();
    tickAndCheck("fill0_t1", 0, 0, 0, 0);
    tickAndCheck("fill0_t2", 0, 0, 0, 0);
    tickAndCheck("fill0_t3", 0, 0, 0, 0);
    tickAndCheck("fill0_t4", 0, 1, 0, 1);
    tickAndCheck("step_t1", 15, 1, 4, 1);
    tickAndCheck("step_t2", 15, 1, 8, 1);
    tickAndCheck("step_t3", 15, 1, 11, 1);
    tickAndCheck("step_t4", 15, 1, 15, 1);
    tickAndCheck("step_t5", 15, 1, 15, 1);

    // Enable stall with the prescaler part way through its count.
    clk_en_i = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      stepCycle();
      checkOutput("prestall_valid", int'(valid_o), 0);
    end
    clk_en_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      stepCycle();
      checkOutput("stall_valid", int'(valid_o), 0);
      checkOutput("stall_value", int'(ADC_value_o), 15);
    end
    clk_en_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      stepCycle();
      if (k == 2) clk_en_i = 1'b0;
      checkOutput($sformatf("resume_valid_c%0d", k), int'(valid_o), (k == 3) ? 1 : 0);
      checkOutput("resume_value", int'(ADC_value_o), 15);
    end

    // Hysteresis: window 8,8,8,8 -> 8,8,8,9 -> 8,8,9,9 -> 8,9,9,10 -> 9,9,10,10.
    doReset();
    tickAndCheck("fill8_t1", 8, 0, 0, 0);
    tickAndCheck("fill8_t2", 8, 0, 0, 0);
    tickAndCheck("fill8_t3", 8, 0, 0, 0);
    tickAndCheck("fill8_t4", 8, 1, 8, 1);
    tickAndCheck("hyst_9a", 9, 1, 8, 1);
    tickAndCheck("hyst_9b", 9, 1, (HYST != 0) ? 8 : 9, 1);
    tickAndCheck("hyst_10a", 10, 1, (HYST != 0) ? 8 : 9, 1);
    tickAndCheck("hyst_10b", 10, 1, 10, 1);

    // Reset in RUN with a result still in the pipeline.
    doReset();
    tickAndCheck("fill12_t1", 12, 0, 0, 0);
    tickAndCheck("fill12_t2", 12, 0, 0, 0);
    tickAndCheck("fill12_t3", 12, 0, 0, 0);
    tickAndCheck("fill12_t4", 12, 1, 12, 1);
    applyStimulus(12);
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_value", int'(ADC_value_o), 0);
    checkOutput("midrst_ready", int'(ready_o), 0);
    checkOutput("midrst_valid", int'(valid_o), 0);
    stepCycle();
    checkOutput("midrst_pending_valid", int'(valid_o), 0);
    rst_i = 1'b0;
    stepCycle();
    checkOutput("midrst_after_valid", int'(valid_o), 0);
    checkOutput("midrst_after_ready", int'(ready_o), 0);
    tickAndCheck("refill_t1", 12, 0, 0, 0);
    tickAndCheck("refill_t2", 12, 0, 0, 0);
    tickAndCheck("refill_t3", 12, 0, 0, 0);
    tickAndCheck("refill_t4", 12, 1, 12, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
